// File: rtl/exhaustive_vector_sequencer_pkg.sv
// Shared types and helpers for the exhaustive vector sweep controller and the
// harness controllers that reuse the response signature.
package trojan_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } seq_state_e;

  localparam int W_DEF      = 3;
  localparam int SETTLE_DEF = 1;
  localparam int SIG_W_DEF  = 16;
  localparam int SIG_W_MAX  = 64;

  // Rotate-left within the low w bits, then fold the response into bit 0.
  // Callers zero-extend their signature to SIG_W_MAX and truncate the result.
  function automatic logic [SIG_W_MAX-1:0] sig_next(input logic [SIG_W_MAX-1:0] sig,
                                                    input logic                 b,
                                                    input int unsigned          w);
    logic [SIG_W_MAX-1:0] mask;
    logic [SIG_W_MAX-1:0] rot;
    mask = (w >= SIG_W_MAX) ? '1 : ((SIG_W_MAX'(1) << w) - SIG_W_MAX'(1));
    rot  = ((sig << 1) | ((sig >> (w - 1)) & SIG_W_MAX'(1))) & mask;
    return rot ^ {{(SIG_W_MAX-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/exhaustive_vector_sequencer_if.sv
// Record handshake between the sweep controller and the downstream logger.
interface exhaustive_vector_sequencer_if #(parameter int W = 3) ();
  logic         rec_valid;
  logic         rec_ready;
  logic [W-1:0] rec_vec;
  logic         rec_resp;

  modport master (output rec_valid, output rec_vec, output rec_resp, input rec_ready);
  modport slave  (input rec_valid, input rec_vec, input rec_resp, output rec_ready);
endinterface

// File: rtl/exhaustive_vector_sequencer_response_signature.sv
// Running rotate-xor response signature plus a count of 1-responses,
// with independent clear and update enables (clear wins).
module response_signature
  import trojan_tb_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clr,
  input  logic             upd,
  input  logic             bit_in,
  output logic [SIG_W-1:0] signature,
  output logic [W:0]       ones_cnt
);

  logic [SIG_W-1:0] sig_q, sig_d;
  logic [W:0]       ones_q, ones_d;

  always_comb begin
    sig_d  = sig_q;
    ones_d = ones_q;
    if (clr) begin
      sig_d  = '0;
      ones_d = '0;
    end else if (upd) begin
      sig_d  = SIG_W'(sig_next(SIG_W_MAX'(sig_q), bit_in, SIG_W));
      ones_d = ones_q + {{W{1'b0}}, bit_in};
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      sig_q  <= '0;
      ones_q <= '0;
    end else begin
      sig_q  <= sig_d;
      ones_q <= ones_d;
    end
  end

  assign signature = sig_q;
  assign ones_cnt  = ones_q;

endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps all 2^W input vectors through a single-output DUT, waits SETTLE
// cycles per vector, and hands each (vector, response) record to a logger.
module exhaustive_vector_sequencer
  import trojan_tb_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int SIG_W  = SIG_W_DEF
) (
  input  logic                          CK,
  input  logic                          reset,
  input  logic                          start,
  output logic [W-1:0]                  dut_in,
  input  logic                          dut_out,
  exhaustive_vector_sequencer_if.master rec,
  output logic                          busy,
  output logic                          done,
  output logic [SIG_W-1:0]              signature,
  output logic [W:0]                    ones_cnt
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  seq_state_e       state_q, state_d;
  logic [W-1:0]     vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     rvec_q, rvec_d;
  logic             rresp_q, rresp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sig_clr, sig_upd;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    rvec_d  = rvec_q;
    rresp_d = rresp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sig_clr = 1'b0;
    sig_upd = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_d   = '0;
          sig_clr = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        cnt_d   = CNT_W'(SETTLE - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CAPTURE: begin
        rresp_d = dut_out;
        rvec_d  = vec_q;
        sig_upd = 1'b1;
        valid_d = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        // Termination compares against all-ones so the last vector is emitted once, never wrapped.
        if (valid_q && rec.rec_ready) begin
          valid_d = 1'b0;
          if (vec_q == {W{1'b1}}) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + W'(1);
            state_d = ST_APPLY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rvec_q  <= '0;
      rresp_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rvec_q  <= rvec_d;
      rresp_q <= rresp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  response_signature #(.W(W), .SIG_W(SIG_W)) u_sig (
    .CK        (CK),
    .reset     (reset),
    .clr       (sig_clr),
    .upd       (sig_upd),
    .bit_in    (dut_out),
    .signature (signature),
    .ones_cnt  (ones_cnt)
  );

  assign dut_in        = vec_q;
  assign rec.rec_valid = valid_q;
  assign rec.rec_vec   = rvec_q;
  assign rec.rec_resp  = rresp_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Directed bench: AND3 sweeps at SETTLE=1 (stall, restart, ignored start,
// mid-sweep reset) and an XOR3 sweep at SETTLE=4.
module tb_exhaustive_vector_sequencer;

  logic CK = 1'b0;
  logic reset = 1'b0;
  logic start1 = 1'b0;
  logic start4 = 1'b0;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  exhaustive_vector_sequencer_if #(.W(3)) rif1 ();
  exhaustive_vector_sequencer_if #(.W(3)) rif4 ();

  logic [2:0]  dut_in1, dut_in4;
  logic        dut_out1, dut_out4;
  logic        busy1, busy4, done1, done4;
  logic [15:0] sig1, sig4;
  logic [3:0]  ones1, ones4;

  assign dut_out1 = &dut_in1;
  assign dut_out4 = ^dut_in4;
  assign rif4.rec_ready = 1'b1;

  exhaustive_vector_sequencer #(.W(3), .SETTLE(1), .SIG_W(16)) u_dut1 (
    .CK(CK), .reset(reset), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
    .rec(rif1.master), .busy(busy1), .done(done1), .signature(sig1), .ones_cnt(ones1)
  );

  exhaustive_vector_sequencer #(.W(3), .SETTLE(4), .SIG_W(16)) u_dut4 (
    .CK(CK), .reset(reset), .start(start4), .dut_in(dut_in4), .dut_out(dut_out4),
    .rec(rif4.master), .busy(busy4), .done(done4), .signature(sig4), .ones_cnt(ones4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Logger model for instance 1: optional 5-cycle stall on vector 3.
  logic [2:0] vlog1 [0:255];
  logic       rlog1 [0:255];
  int  n1 = 0, done_cnt1 = 0, done_cyc1 = 0, stall_total = 0;
  logic stall_en = 1'b0;

  always @(negedge CK) begin
    logic rdy;
    rdy = 1'b1;
    if (stall_en && rif1.rec_valid && rif1.rec_vec == 3'd3 && rif1.rec_resp == 1'b0 &&
        stall_total < 5) begin
      rdy = 1'b0;
      stall_total = stall_total + 1;
    end
    rif1.rec_ready = rdy;
    if (rif1.rec_valid && rdy && n1 < 256) begin
      vlog1[n1] = rif1.rec_vec;
      rlog1[n1] = rif1.rec_resp;
      n1 = n1 + 1;
    end
    if (done1) begin
      done_cnt1 = done_cnt1 + 1;
      done_cyc1 = cyc;
    end
  end

  logic [2:0] vlog4 [0:63];
  logic       rlog4 [0:63];
  int  n4 = 0, done_cnt4 = 0, done_cyc4 = 0;

  always @(negedge CK) begin
    if (rif4.rec_valid && n4 < 64) begin
      vlog4[n4] = rif4.rec_vec;
      rlog4[n4] = rif4.rec_resp;
      n4 = n4 + 1;
    end
    if (done4) begin
      done_cnt4 = done_cnt4 + 1;
      done_cyc4 = cyc;
    end
  end

  int st_cyc;

  task automatic pulse_start1();
    @(negedge CK);
    start1 = 1'b1;
    st_cyc = cyc;
    @(negedge CK);
    start1 = 1'b0;
  endtask

  task automatic wait_done1(input int d0, input int budget);
    int k = 0;
    while (done_cnt1 == d0 && k < budget) begin
      @(negedge CK);
      #1;
      k++;
    end
    chk("done1_seen", 32'(done_cnt1 != d0), 32'd1);
  endtask

  task automatic check_stream1(input string tag, input int base);
    logic [2:0] v;
    chk({tag, "_nrec"}, 32'(n1 - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      chk($sformatf("%s_vec%0d", tag, i), 32'(vlog1[base + i]), 32'(v));
      chk($sformatf("%s_resp%0d", tag, i), 32'(rlog1[base + i]), 32'(&v));
    end
  endtask

  initial begin
    int d0, base, k;
    logic [2:0] v;

    // Reset values
    repeat (3) @(negedge CK);
    #1;
    chk("rst_dut_in", 32'(dut_in1), 32'd0);
    chk("rst_valid", 32'(rif1.rec_valid), 32'd0);
    chk("rst_vec", 32'(rif1.rec_vec), 32'd0);
    chk("rst_resp", 32'(rif1.rec_resp), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_sig", 32'(sig1), 32'd0);
    chk("rst_ones", 32'(ones1), 32'd0);
    @(negedge CK);
    reset = 1'b1;

    // AND3 sweep, logger always ready
    d0 = done_cnt1; base = n1;
    pulse_start1();
    chk("t1_busy", 32'(busy1), 32'd1);
    chk("t1_dut_in0", 32'(dut_in1), 32'd0);
    wait_done1(d0, 100);
    chk("t1_latency", 32'(done_cyc1 - st_cyc), 32'd33);
    chk("t1_ones", 32'(ones1), 32'd1);
    chk("t1_sig", 32'(sig1), 32'h0001);
    chk("t1_busy_done", 32'(busy1), 32'd0);
    chk("t1_dut_in_last", 32'(dut_in1), 32'd7);
    repeat (3) @(negedge CK);
    chk("t1_done_once", 32'(done_cnt1 - d0), 32'd1);
    chk("t1_done_low", 32'(done1), 32'd0);
    chk("t1_sig_hold", 32'(sig1), 32'h0001);
    check_stream1("t1", base);

    // Restart from DONE with a 5-cycle logger stall on vector 3
    stall_en = 1'b1;
    d0 = done_cnt1; base = n1;
    pulse_start1();
    chk("t2_sig_clr", 32'(sig1), 32'd0);
    chk("t2_ones_clr", 32'(ones1), 32'd0);
    wait_done1(d0, 150);
    stall_en = 1'b0;
    chk("t2_stall_cycles", 32'(stall_total), 32'd5);
    chk("t2_ones", 32'(ones1), 32'd1);
    chk("t2_sig", 32'(sig1), 32'h0001);
    check_stream1("t2", base);

    // Start pulsed during EMIT of vector 2 is ignored
    d0 = done_cnt1; base = n1;
    pulse_start1();
    k = 0;
    while (!(rif1.rec_valid && rif1.rec_vec == 3'd2) && k < 100) begin
      @(negedge CK);
      k++;
    end
    chk("t3_reach_v2", 32'(k < 100), 32'd1);
    start1 = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    chk("t3_busy", 32'(busy1), 32'd1);
    chk("t3_dut_in", 32'(dut_in1), 32'd3);
    wait_done1(d0, 100);
    chk("t3_latency", 32'(done_cyc1 - st_cyc), 32'd33);
    repeat (2) @(negedge CK);
    chk("t3_done_once", 32'(done_cnt1 - d0), 32'd1);
    check_stream1("t3", base);

    // XOR3 at SETTLE=4
    d0 = done_cnt4; base = n4;
    @(negedge CK);
    start4 = 1'b1;
    st_cyc = cyc;
    @(negedge CK);
    start4 = 1'b0;
    k = 0;
    while (done_cnt4 == d0 && k < 150) begin
      @(negedge CK);
      #1;
      k++;
    end
    chk("t4_done_seen", 32'(done_cnt4 != d0), 32'd1);
    chk("t4_latency", 32'(done_cyc4 - st_cyc), 32'd57);
    chk("t4_ones", 32'(ones4), 32'd4);
    chk("t4_sig", 32'(sig4), 32'h0069);
    chk("t4_nrec", 32'(n4 - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      chk($sformatf("t4_vec%0d", i), 32'(vlog4[base + i]), 32'(v));
      chk($sformatf("t4_resp%0d", i), 32'(rlog4[base + i]), 32'(^v));
    end

    // Reset during SETTLE of vector 5, then a fresh sweep
    pulse_start1();
    k = 0;
    while (dut_in1 != 3'd5 && k < 100) begin
      @(negedge CK);
      k++;
    end
    chk("t5_reach_v5", 32'(k < 100), 32'd1);
    @(negedge CK);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_dut_in", 32'(dut_in1), 32'd0);
    chk("t5_valid", 32'(rif1.rec_valid), 32'd0);
    chk("t5_vec", 32'(rif1.rec_vec), 32'd0);
    chk("t5_resp", 32'(rif1.rec_resp), 32'd0);
    chk("t5_busy", 32'(busy1), 32'd0);
    chk("t5_done", 32'(done1), 32'd0);
    chk("t5_sig", 32'(sig1), 32'd0);
    chk("t5_ones", 32'(ones1), 32'd0);
    @(negedge CK);
    reset = 1'b1;
    d0 = done_cnt1; base = n1;
    pulse_start1();
    wait_done1(d0, 100);
    chk("t5_latency", 32'(done_cyc1 - st_cyc), 32'd33);
    chk("t5_sig_end", 32'(sig1), 32'h0001);
    check_stream1("t5", base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
